// File: rtl/fan_motor_drive.sv
// fan_motor_drive: mode duty mux, slew-limited duty ramp and frame-synchronous DC-motor PWM.
// Kick-start from standstill is built only when FAN_KICKSTART_EN is defined.
module fan_motor_drive #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PWM_FREQ   = 100,
    parameter int RAMP_HZ    = 1000,
    parameter int STEP       = 1,
    parameter int KICK_DUTY  = 255,
    parameter int KICK_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [1:0] mode_sel,
    input  logic [7:0] duty_a,
    input  logic [7:0] duty_b,
    input  logic [7:0] duty_c,
    output logic       pwm,
    output logic [7:0] duty_out,
    output logic       busy
);
    localparam int RAMP_DIV = (CLK_HZ / RAMP_HZ > 1) ? CLK_HZ / RAMP_HZ : 1;
    localparam int PRE_DIV  = (CLK_HZ / (PWM_FREQ * 256) > 1) ? CLK_HZ / (PWM_FREQ * 256) : 1;
    localparam int RW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, RUN = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [7:0]    duty_nxt, target, ramped;
    logic [8:0]    step9, gap9, ramp9;
    logic [RW-1:0] ramp_cnt;
    logic          tick;
`ifdef FAN_KICKSTART_EN
    localparam int KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
    logic [KW-1:0] kick_cnt, kick_nxt;
`endif

    always_comb begin
        case (mode_sel)
            2'd1:    target = duty_a;
            2'd2:    target = duty_b;
            2'd3:    target = duty_c;
            default: target = 8'd0;
        endcase
    end

    assign tick = (ramp_cnt == RW'(RAMP_DIV - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) ramp_cnt <= '0;
        else         ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
    end

    // One slew step toward target; bit 8 would only ever flag a wrap, so clamp on it.
    always_comb begin
        step9 = 9'(STEP);
        if (target >= duty_out) begin
            gap9  = {1'b0, target} - {1'b0, duty_out};
            ramp9 = {1'b0, duty_out} + ((gap9 < step9) ? gap9 : step9);
        end else begin
            gap9  = {1'b0, duty_out} - {1'b0, target};
            ramp9 = {1'b0, duty_out} - ((gap9 < step9) ? gap9 : step9);
        end
        ramped = ramp9[8] ? 8'hFF : ramp9[7:0];
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
`ifdef FAN_KICKSTART_EN
        kick_nxt  = kick_cnt;
`endif
        case (state)
            IDLE: if (tick && target != 8'd0) begin
`ifdef FAN_KICKSTART_EN
                state_nxt = KICK;
                duty_nxt  = 8'(KICK_DUTY);
                kick_nxt  = '0;
`else
                state_nxt = RUN;
                duty_nxt  = ramped;
`endif
            end
`ifdef FAN_KICKSTART_EN
            // Abort does not wait for a tick; the motor must stop driving at once.
            KICK: if (target == 8'd0) begin
                state_nxt = IDLE;
                duty_nxt  = 8'd0;
                kick_nxt  = '0;
            end else if (tick) begin
                if (kick_cnt == KW'(KICK_TICKS - 1)) begin
                    state_nxt = RUN;
                    duty_nxt  = target;
                    kick_nxt  = '0;
                end else begin
                    kick_nxt = kick_cnt + 1'b1;
                end
            end
`endif
            RUN: if (tick) begin
                duty_nxt = ramped;
                if (ramped == 8'd0) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                duty_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state    <= IDLE;
            duty_out <= 8'd0;
`ifdef FAN_KICKSTART_EN
            kick_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
`ifdef FAN_KICKSTART_EN
            kick_cnt <= kick_nxt;
`endif
        end
    end

    // Gated by reset so busy reads 0 for as long as reset is held.
    assign busy = !reset_p && ((duty_out != target) || (state == KICK));

    logic [PW-1:0] pre_cnt;
    logic [7:0]    cnt, duty_lat;
    logic          adv;

    assign adv = (pre_cnt == PW'(PRE_DIV - 1));

    // duty_lat only moves on the 255->0 wrap so a frame is never cut short.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_cnt  <= '0;
            cnt      <= 8'd0;
            duty_lat <= 8'd0;
            pwm      <= 1'b0;
        end else begin
            pre_cnt <= adv ? '0 : pre_cnt + 1'b1;
            if (adv) begin
                cnt <= cnt + 8'd1;
                if (cnt == 8'hFF) duty_lat <= duty_out;
            end
            pwm <= (cnt < duty_lat);
        end
    end
endmodule

// File: tb/tb_fan_motor_drive.sv
// Scoreboard bench for fan_motor_drive: expected duty_out steps are queued by the stimulus
// and popped by a monitor on every duty_out change; follows FAN_KICKSTART_EN like the RTL.
module tb_fan_motor_drive;
    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [1:0] mode_sel = 2'd0;
    logic [7:0] duty_a = 8'd0, duty_b = 8'd0, duty_c = 8'd0;
    logic       pwm, busy;
    logic [7:0] duty_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_q[$];

    fan_motor_drive #(
        .CLK_HZ(25600), .PWM_FREQ(100), .RAMP_HZ(2560),
        .STEP(25), .KICK_DUTY(255), .KICK_TICKS(3)
    ) dut (
        .clk(clk), .reset_p(reset_p), .mode_sel(mode_sel),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .pwm(pwm), .duty_out(duty_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic exp(input int v);
        exp_q.push_back(v);
    endtask

    task automatic wait_duty(input string name, input int v, output int t);
        int n = 0;
        while (duty_out != v && n < 400) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        chk(name, int'(duty_out), v);
    endtask

    task automatic frame_sync();
        int   n = 0;
        logic p;
        logic found;
        p = pwm;
        @(negedge clk);
        found = (p == 1'b0 && pwm == 1'b1);
        while (!found && n < 600) begin
            p = pwm;
            @(negedge clk);
            found = (p == 1'b0 && pwm == 1'b1);
            n++;
        end
        chk("frame_sync", int'(found), 1);
    endtask

    // Counts pwm over 256 samples starting with the current one; optionally retargets mid-way.
    task automatic frame_count(input int change_at, input logic [7:0] new_duty, output int h);
        h = int'(pwm);
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (i == change_at) duty_a = new_duty;
            h += int'(pwm);
        end
    endtask

    // Monitor: each duty_out change must match the head of the expected queue.
    initial begin
        logic [7:0] prev;
        prev = 8'd0;
        forever begin
            @(negedge clk);
            if (duty_out != prev) begin
                if (exp_q.size() == 0) chk("duty_unexpected", int'(duty_out), int'(prev));
                else                   chk("duty_seq", int'(duty_out), exp_q.pop_front());
                prev = duty_out;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int t0, t1, h;
        repeat (3) @(negedge clk);
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_busy", int'(busy), 0);
        reset_p = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Spin up to 80
        mode_sel = 2'd1; duty_a = 8'd80;
`ifdef FAN_KICKSTART_EN
        exp(255); exp(80);
        wait_duty("kick_on", 255, t0);
        chk("kick_busy", int'(busy), 1);
        wait_duty("kick_load", 80, t1);
        chk("kick_len", t1 - t0, 30);
`else
        exp(25); exp(50); exp(75); exp(80);
        wait_duty("ramp_first", 25, t0);
        chk("ramp_busy", int'(busy), 1);
        wait_duty("ramp_final", 80, t1);
        chk("ramp_len", t1 - t0, 30);
`endif
        @(negedge clk);
        chk("settled_busy", int'(busy), 0);

        // Ramp up, redirect mid-ramp to a zero source
        exp(105); exp(130); exp(155);
        duty_a = 8'd255;
        wait_duty("redirect_peak", 155, t0);
        exp(130); exp(105); exp(80); exp(55); exp(30); exp(5); exp(0);
        mode_sel = 2'd2; duty_b = 8'd0;
        wait_duty("down_to_zero", 0, t0);
        @(negedge clk);
        chk("zero_busy", int'(busy), 0);
        repeat (300) @(negedge clk);
        frame_count(0, 8'd0, h);
        chk("pwm_off_high", h, 0);

        // Steady 128, then retarget mid-frame
        mode_sel = 2'd1; duty_a = 8'd128;
`ifdef FAN_KICKSTART_EN
        exp(255); exp(128);
`else
        exp(25); exp(50); exp(75); exp(100); exp(125); exp(128);
`endif
        wait_duty("steady_128", 128, t0);
        repeat (300) @(negedge clk);
        frame_sync();
        exp(153); exp(178); exp(200);
        frame_count(60, 8'd200, h);
        chk("frame_128_high", h, 128);
        @(negedge clk);
        frame_count(0, 8'd200, h);
        chk("frame_200_high", h, 200);

        // Back down to off
        exp(175); exp(150); exp(125); exp(100); exp(75); exp(50); exp(25); exp(0);
        mode_sel = 2'd0;
        wait_duty("off_again", 0, t0);

        // Reset mid-spin-up, then a fresh start
        mode_sel = 2'd1; duty_a = 8'd80;
`ifdef FAN_KICKSTART_EN
        exp(255);
        wait_duty("pre_reset_kick", 255, t0);
`else
        exp(25); exp(50);
        wait_duty("pre_reset_ramp", 50, t0);
`endif
        repeat (5) @(negedge clk);
        exp(0);
        #2 reset_p = 1'b1;
        #1;
        chk("async_rst_duty", int'(duty_out), 0);
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
`ifdef FAN_KICKSTART_EN
        exp(255); exp(80);
        wait_duty("rekick_on", 255, t0);
        wait_duty("rekick_load", 80, t1);
        chk("rekick_len", t1 - t0, 30);

        // Abort a kick by dropping the target
        exp(55); exp(30); exp(5); exp(0);
        mode_sel = 2'd0;
        wait_duty("pre_abort_off", 0, t0);
        exp(255);
        mode_sel = 2'd1;
        wait_duty("abort_kick_on", 255, t0);
        repeat (5) @(negedge clk);
        exp(0);
        mode_sel = 2'd0;
        @(negedge clk);
        chk("kick_abort_duty", int'(duty_out), 0);
        chk("kick_abort_busy", int'(busy), 0);
`else
        exp(25); exp(50); exp(75); exp(80);
        wait_duty("reramp_first", 25, t0);
        wait_duty("reramp_final", 80, t1);
        chk("reramp_len", t1 - t0, 30);
`endif
        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fan_motor_drive.md
# fan_motor_drive

Output stage of the fan datapath. It sits directly downstream of the local mode blocks (manual, timer, natural wind) and consumes the 8-bit `duty` each one produces. It selects the active mode's duty and slew-limits it so the motor never sees step changes. It then generates the DC-motor PWM, with an optional kick-start pulse when spinning up from standstill.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `PWM_FREQ`, 100, PWM frame rate in Hz; one frame is 256 counts.
- `RAMP_HZ`, 1000, ramp-tick rate in Hz.
- `STEP`, 1, maximum duty change per ramp tick (1..255).
- `KICK_DUTY`, 255, duty applied during kick-start.
- `KICK_TICKS`, 200, kick-start length in ramp ticks (≥1).
- `clk  in  1`: system clock, rising edge.
- `reset_p  in  1`: asynchronous, active-high reset.
- `mode_sel  in  2`: source select. 0 = off (target 0), 1 = `duty_a`, 2 = `duty_b`, 3 = `duty_c`.
- `duty_a`, `duty_b`, `duty_c`  in  8 each: mode duties.
- `pwm  out  1`: motor PWM.
- `duty_out  out  8`: duty currently applied, registered.
- `busy  out  1`: high while `duty_out` ≠ target or the block is in KICK.

## Operation
- Target is `mux(mode_sel)` and is re-evaluated every cycle. There is no latching, so a mode change mid-ramp simply redirects the ramp.
- Ramp tick: a one-cycle pulse every `RAMP_DIV = CLK_HZ/RAMP_HZ` cycles, from a free-running counter. Integer truncation applies.
- FSM states are IDLE, KICK and RUN.
- **IDLE** (`duty_out` = 0):
  - On a tick with target ≠ 0, go to KICK if enabled, else to RUN.
  - On a tick with target = 0, stay in IDLE.
- **KICK**:
  - `duty_out` = `KICK_DUTY` for `KICK_TICKS` ticks.
  - On the final tick, `duty_out` = target (exact load, no ramp) and the FSM goes to RUN.
  - If target drops to 0 during KICK, go to IDLE with `duty_out` = 0 on the next clock, without waiting for a tick.
- **RUN**, on each tick:
  - If `duty_out` < target: `duty_out` += min(`STEP`, target − `duty_out`).
  - If `duty_out` > target: `duty_out` −= min(`STEP`, `duty_out` − target).
  - Use 9-bit intermediates so the result never overshoots or wraps.
  - Reaching 0 moves the FSM to IDLE.
- **PWM generation**:
  - A prescaler of `CLK_HZ/(PWM_FREQ*256)` cycles (minimum 1) advances an 8-bit frame counter `cnt` from 0 to 255, wrapping to 0.
  - `duty_out` is sampled into `duty_lat` when `cnt` wraps 255→0 (frame boundary). A change therefore never cuts a frame.
  - `pwm` = (`cnt` < `duty_lat`), registered.
  - `duty_lat` = 0 gives constant low. `duty_lat` = 255 gives high for 255 of 256 counts.

## Timing
- Reset values:
  - `duty_out` = 0, `duty_lat` = 0, `pwm` = 0, `busy` = 0.
  - State is IDLE.
  - All counters (prescaler, ramp divider, `cnt`, kick counter) are 0.
- Reset is honoured at any point, including mid-ramp or mid-KICK, and every output is at its reset value on the same edge.
- `duty_out` updates on the clock edge following the tick cycle.
- Latency from a `duty_out` change to `pwm` is up to one full frame plus 1 cycle (the `pwm` register).
- `busy` is combinational from registered state and the current target.
- A tick and a target change in the same cycle: the ramp uses the new target.

## Configuration
- Macro: `FAN_KICKSTART_EN`.
- Defined: KICK state present, behaving as above.
- Undefined: the KICK state and kick counter are not synthesised, `KICK_*` parameters are ignored, and IDLE goes directly to RUN, ramping from 0 by `STEP`.

## Test plan
Bench parameters: `CLK_HZ`=25600, `PWM_FREQ`=100 (prescale 1), `RAMP_HZ`=2560 (tick every 10 cycles), `STEP`=25, `KICK_TICKS`=3.

- Kick disabled; `mode_sel`=1, `duty_a`=80. Required: `duty_out` steps 0→25→50→75→80 on successive ticks, then `busy`=0.
- Kick enabled; same stimulus. Required: `duty_out`=255 for 3 ticks, then 80.
- In RUN at 80, set `duty_a`=255, then switch `mode_sel`=2 with `duty_b`=0 mid-ramp. Required: rises, then decreases by 25 per tick to 0, ending in IDLE and `pwm` constant low.
- `duty_out`=128 steady. Required: `pwm` high exactly 128 of every 256 cycles. Changing target mid-frame must not alter the current frame's high count.
- Assert `reset_p` during KICK. Required: `duty_out`, `pwm` and `busy` are 0 immediately. After release with target 80, a fresh kick of 3 ticks follows.
- Drop target to 0 during KICK. Required: `duty_out`=0 on the next clock, with no tick wait.
